gcm_req_scheduler: RTL and testbench



---
 rtl/gcm_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_gcm_req_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_req_scheduler.sv
// Round-robin packet scheduler sharing one AES-GCM engine between NUM_REQ requesters.
// Forwards whole packets to the engine and routes returning ciphertext back via a tag FIFO.
module gcm_req_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int TAG_DEPTH  = 32,
  parameter int MAX_BLOCKS = 16,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*128-1:0]   i_req_block,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_aes_new,
  output logic                     o_aes_last,
  output logic [127:0]             o_aes_plain,
  input  logic                     i_aes_cp_ready,
  input  logic [127:0]             i_aes_cipher,
  output logic                     o_ct_valid,
  output logic [127:0]             o_ct_data,
  output logic [IDW-1:0]           o_ct_id,
  output logic                     o_ct_last,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   grant, grant_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]    blk_cnt, blk_cnt_nxt;

  logic [IDW:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [IDW:0]     tag_head;

  logic             fifo_full, fifo_empty;
  logic             accept, acc_last, at_max, trunc;
  logic             found;
  logic [IDW-1:0]   pick;
  logic             push, pop;
  logic [127:0]     sel_block;

  assign fifo_full  = (count == CW'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = accept;
  assign pop        = i_aes_cp_ready & ~fifo_empty;
  assign tag_head   = tag_mem[rd_ptr];
  assign sel_block  = i_req_block[128*int'(grant) +: 128];
  assign o_busy     = (state != IDLE) | ~fifo_empty;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    blk_cnt_nxt = blk_cnt;
    o_req_ready = '0;
    accept      = 1'b0;
    acc_last    = 1'b0;
    at_max      = 1'b0;
    trunc       = 1'b0;
    found       = 1'b0;
    pick        = rr_ptr;

    case (state)
      IDLE: begin
        // Scan offsets high to low so the smallest offset from rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (i_req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            pick  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
          end
        end
        if (found && !fifo_full) begin
          grant_nxt = pick;
          state_nxt = STREAM;
        end
      end

      STREAM: begin
        o_req_ready[grant] = ~fifo_full;
        accept             = i_req_valid[grant] & ~fifo_full;
        at_max             = (blk_cnt == BW'(MAX_BLOCKS - 1));
        acc_last           = i_req_last[grant] | at_max;
        if (accept) begin
          blk_cnt_nxt = blk_cnt + 1'b1;
          if (acc_last) begin
            state_nxt  = GAP;
            rr_ptr_nxt = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            trunc      = ~i_req_last[grant];
          end
        end
      end

      GAP: begin
        state_nxt   = IDLE;
        blk_cnt_nxt = '0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      blk_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_aes_new   <= 1'b0;
      o_aes_last  <= 1'b0;
      o_aes_plain <= '0;
      o_ct_valid  <= 1'b0;
      o_ct_data   <= '0;
      o_ct_id     <= '0;
      o_ct_last   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      blk_cnt    <= blk_cnt_nxt;
      o_aes_new  <= accept;
      o_aes_last <= accept & acc_last;
      if (accept) o_aes_plain <= sel_block;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      o_ct_valid <= pop;
      if (pop) begin
        o_ct_data <= i_aes_cipher;
        o_ct_id   <= tag_head[IDW:1];
        o_ct_last <= tag_head[0];
      end
      o_err <= trunc | (i_aes_cp_ready & fifo_empty);
    end
  end

  // NOTE: tag storage is not reset; the reset pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= {grant, acc_last};
  end

endmodule

// File: tb/tb_gcm_req_scheduler.sv
// Directed self-checking bench for gcm_req_scheduler (NUM_REQ=2, TAG_DEPTH=4, MAX_BLOCKS=16).
module tb_gcm_req_scheduler;

  localparam int NR = 2;
  localparam int TD = 4;
  localparam int MB = 16;
  localparam logic [127:0] PT  = 128'hD9313225F88406E5A55909C5AFF5269A;
  localparam logic [127:0] CK  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] CT0 = 128'h42831EC2217774244B7221B784D0D49C;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     i_req_valid;
  logic [NR*128-1:0] i_req_block;
  logic [NR-1:0]     i_req_last;
  logic [NR-1:0]     o_req_ready;
  logic              o_aes_new, o_aes_last;
  logic [127:0]      o_aes_plain;
  logic              i_aes_cp_ready;
  logic [127:0]      i_aes_cipher;
  logic              o_ct_valid;
  logic [127:0]      o_ct_data;
  logic [0:0]        o_ct_id;
  logic              o_ct_last, o_busy, o_err;

  logic              auto_en, auto_cp, man_cp;
  logic [127:0]      auto_ct, man_ct;

  typedef struct {
    logic         last;
    logic [127:0] data;
    int           cyc;
    logic         id;
  } ev_t;

  ev_t aes_q[$];
  ev_t ct_q[$];
  int  cyc;
  int  err_pulses;
  int  checks;
  int  errors;

  gcm_req_scheduler #(.NUM_REQ(NR), .TAG_DEPTH(TD), .MAX_BLOCKS(MB)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_block(i_req_block), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready),
    .o_aes_new(o_aes_new), .o_aes_last(o_aes_last), .o_aes_plain(o_aes_plain),
    .i_aes_cp_ready(i_aes_cp_ready), .i_aes_cipher(i_aes_cipher),
    .o_ct_valid(o_ct_valid), .o_ct_data(o_ct_data), .o_ct_id(o_ct_id), .o_ct_last(o_ct_last),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  assign i_aes_cp_ready = auto_en ? auto_cp : man_cp;
  assign i_aes_cipher   = auto_en ? auto_ct : man_ct;

  // Engine model: answers each forwarded block one cycle later with plain ^ CK.
  always @(negedge clk) begin
    auto_cp = o_aes_new;
    auto_ct = o_aes_plain ^ CK;
  end

  always @(negedge clk) begin
    cyc++;
    if (o_aes_new)  aes_q.push_back('{last: o_aes_last, data: o_aes_plain, cyc: cyc, id: 1'b0});
    if (o_ct_valid) ct_q.push_back('{last: o_ct_last, data: o_ct_data, cyc: cyc, id: o_ct_id[0]});
    if (o_err)      err_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input int r, input int idx);
    return {8'(160 + r), 112'h0, 8'(idx)};
  endfunction

  task automatic do_reset(input logic auto_mode);
    @(negedge clk);
    reset       = 1'b1;
    i_req_valid = '0;
    i_req_last  = '0;
    man_cp      = 1'b0;
    auto_en     = auto_mode;
    #2;
    aes_q.delete();
    ct_q.delete();
    err_pulses = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one block on requester r and return at the negedge after it is accepted.
  task automatic put(input int r, input logic [127:0] d, input logic l);
    int t;
    i_req_valid[r]            = 1'b1;
    i_req_last[r]             = l;
    i_req_block[128*r +: 128] = d;
    t = 0;
    while (!o_req_ready[r] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("put_timeout", o_req_ready[r], 1);
    @(negedge clk);
    i_req_valid[r] = 1'b0;
    i_req_last[r]  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int sent [NR];
    logic [NR-1:0] acc;
    int guard;

    checks = 0; errors = 0; cyc = 0; err_pulses = 0;
    reset = 1'b1; i_req_valid = '0; i_req_last = '0; i_req_block = '0;
    man_cp = 1'b0; man_ct = '0; auto_en = 1'b0;

    // Reset state
    idle(2);
    check("rst_ready", o_req_ready, 0);
    check("rst_new",   o_aes_new, 0);
    check("rst_last",  o_aes_last, 0);
    check("rst_plain", o_aes_plain, 0);
    check("rst_ctv",   o_ct_valid, 0);
    check("rst_ctd",   o_ct_data, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_err",   o_err, 0);

    // Single 4-block packet from requester 0, engine answered manually
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) put(0, PT, i == 3);
    check("p1_new_last", {o_aes_new, o_aes_last}, 2'b11);
    @(negedge clk);
    check("p1_gap_new", o_aes_new, 0);
    check("p1_busy", o_busy, 1);
    for (int i = 0; i < 4; i++) begin
      man_ct = CT0 + 128'(i);
      man_cp = 1'b1;
      @(negedge clk);
    end
    man_cp = 1'b0;
    idle(2);
    check("p1_aes_cnt", aes_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < aes_q.size()) begin
      check("p1_aes_data", aes_q[i].data, PT);
      check("p1_aes_last", aes_q[i].last, i == 3);
      check("p1_aes_cyc",  aes_q[i].cyc - aes_q[0].cyc, i);
    end
    check("p1_ct_cnt", ct_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < ct_q.size()) begin
      check("p1_ct_id",   ct_q[i].id, 0);
      check("p1_ct_last", ct_q[i].last, i == 3);
      check("p1_ct_data", ct_q[i].data, CT0 + 128'(i));
    end
    check("p1_idle_busy", o_busy, 0);

    // Both requesters continuously valid with 2-block packets
    do_reset(1'b1);
    sent[0] = 0; sent[1] = 0; guard = 0;
    while ((sent[0] < 4 || sent[1] < 4) && guard < 100) begin
      for (int r = 0; r < NR; r++) begin
        i_req_valid[r]            = sent[r] < 4;
        i_req_last[r]             = sent[r] % 2 == 1;
        i_req_block[128*r +: 128] = blk(r, sent[r]);
      end
      acc = i_req_valid & o_req_ready;
      @(negedge clk);
      for (int r = 0; r < NR; r++) sent[r] += int'(acc[r]);
      guard++;
    end
    i_req_valid = '0; i_req_last = '0;
    if (guard >= 100) check("rr_timeout", 2'(sent[0] + sent[1]), 8);
    idle(5);
    check("rr_aes_cnt", aes_q.size(), 8);
    check("rr_ct_cnt", ct_q.size(), 8);
    for (int k = 0; k < 8; k++) if (k < aes_q.size() && k < ct_q.size()) begin
      check("rr_aes_data", aes_q[k].data, blk((k / 2) % 2, (k / 4) * 2 + k % 2));
      check("rr_aes_last", aes_q[k].last, k % 2 == 1);
      check("rr_ct_id",    ct_q[k].id, (k / 2) % 2);
      check("rr_ct_last",  ct_q[k].last, k % 2 == 1);
      check("rr_ct_data",  ct_q[k].data, blk((k / 2) % 2, (k / 4) * 2 + k % 2) ^ CK);
    end
    if (aes_q.size() > 2) check("rr_pkt_gap", aes_q[2].cyc - aes_q[1].cyc, 3);

    // Valid gap inside a packet
    do_reset(1'b1);
    put(0, blk(0, 1), 1'b0);
    put(0, blk(0, 2), 1'b0);
    idle(2);
    put(0, blk(0, 3), 1'b1);
    idle(4);
    check("gap_aes_cnt", aes_q.size(), 3);
    if (aes_q.size() == 3) begin
      check("gap_cyc_12", aes_q[1].cyc - aes_q[0].cyc, 1);
      check("gap_cyc_23", aes_q[2].cyc - aes_q[1].cyc, 3);
      check("gap_lasts", {aes_q[0].last, aes_q[1].last, aes_q[2].last}, 3'b001);
    end
    check("gap_ct_cnt", ct_q.size(), 3);

    // 20 blocks without last: truncation at block 16, then a new 4-block packet
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) put(0, blk(0, i + 1), 1'b0);
    idle(5);
    check("trunc_aes_cnt", aes_q.size(), 20);
    check("trunc_ct_cnt", ct_q.size(), 20);
    for (int i = 0; i < 20; i++) if (i < aes_q.size() && i < ct_q.size()) begin
      check("trunc_aes_last", aes_q[i].last, i == 15);
      check("trunc_aes_data", aes_q[i].data, blk(0, i + 1));
      check("trunc_ct_last",  ct_q[i].last, i == 15);
    end
    check("trunc_err_cnt", err_pulses, 1);

    // Tag FIFO full with a silent engine
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) put(0, blk(0, i), 1'b0);
    i_req_valid[0] = 1'b1;
    i_req_last[0]  = 1'b0;
    i_req_block[127:0] = blk(0, 4);
    check("full_ready", o_req_ready[0], 0);
    check("full_busy", o_busy, 1);
    idle(2);
    check("full_ready_hold", o_req_ready[0], 0);
    man_ct = CT0;
    man_cp = 1'b1;
    @(negedge clk);
    man_cp = 1'b0;
    check("full_ready_back", o_req_ready[0], 1);
    check("full_ctv", o_ct_valid, 1);
    @(negedge clk);
    i_req_valid[0] = 1'b0;
    idle(2);
    check("full_aes_cnt", aes_q.size(), 5);

    // Reset asserted mid-STREAM after 2 blocks
    do_reset(1'b0);
    put(0, blk(0, 7), 1'b0);
    put(0, blk(0, 8), 1'b0);
    check("mid_busy", o_busy, 1);
    check("mid_new", o_aes_new, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_new",   o_aes_new, 0);
    check("arst_last",  o_aes_last, 0);
    check("arst_plain", o_aes_plain, 0);
    check("arst_busy",  o_busy, 0);
    check("arst_ready", o_req_ready, 0);
    check("arst_ctv",   o_ct_valid, 0);
    check("arst_err",   o_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    man_ct = CT0;
    man_cp = 1'b1;
    @(negedge clk);
    man_cp = 1'b0;
    check("arst_cp_err", o_err, 1);
    check("arst_cp_ctv", o_ct_valid, 0);
    @(negedge clk);
    check("arst_err_pulse", o_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
